// File: rtl/div_pkg.sv
// Shared types and constants for the div_unit signed restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);
  localparam logic [DEFAULT_WIDTH-1:0] MIN_INT = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem stays below |divisor| <= 2^(WIDTH-1), so bit WIDTH of trial is a true sign bit.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    next_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: IDLE -> RUN (WIDTH iterations) -> FIX.
// Optional DIV_EARLY_EXIT_EN sends divide-by-zero and MIN/-1 straight to FIX.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output div_state_e       dbg_state
);

  // Handshake: ctrl_DIV is a request accepted on any edge (it aborts work in flight);
  // data_resultRDY is a one-cycle valid with no back-pressure, results hold until the next completion.

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r, dividend_r;
  logic             sign_q, sign_r, zero_r, ovf_r;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] abs_a, abs_b, fix_q, fix_r;
  logic             zero_in, ovf_in, early, fix_exc;
  div_state_e       start_state;

  assign dbg_state = state;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  always_comb begin
    abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    zero_in = (data_operandB == '0);
    ovf_in  = (data_operandA == MIN_VAL) && (data_operandB == '1);
  end

`ifdef DIV_EARLY_EXIT_EN
  assign early = zero_in | ovf_in;
`else
  assign early = 1'b0;
`endif

  assign start_state = early ? FIX : RUN;

  // Exceptional cases override whatever the iteration produced.
  always_comb begin
    fix_exc = zero_r | ovf_r;
    fix_q   = sign_q ? -quo_r : quo_r;
    fix_r   = sign_r ? -rem_r : rem_r;
    if (zero_r) begin
      fix_q = '0;
      fix_r = dividend_r;
    end else if (ovf_r) begin
      fix_q = MIN_VAL;
      fix_r = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem_r          <= '0;
      quo_r          <= '0;
      dvsr_r         <= '0;
      dividend_r     <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      zero_r         <= 1'b0;
      ovf_r          <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        RUN: begin
          if (!ctrl_DIV) begin
            rem_r <= step_rem;
            quo_r <= step_quo;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          data_result    <= fix_q;
          data_remainder <= fix_r;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: ;
      endcase
      // A start overrides the case above; on the FIX edge the finishing flag must survive.
      if (ctrl_DIV) begin
        rem_r      <= '0;
        quo_r      <= abs_a;
        dvsr_r     <= abs_b;
        dividend_r <= data_operandA;
        sign_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        sign_r     <= data_operandA[WIDTH-1];
        zero_r     <= zero_in;
        ovf_r      <= ovf_in;
        cnt        <= '0;
        busy       <= 1'b1;
        state      <= start_state;
        if (state != FIX) data_exception <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed sign/exception/abort cases plus randomized ops vs. an arithmetic model.
module tb_div_unit;
  import div_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;
`ifdef DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             ctrl_DIV;
  logic [W-1:0]     data_operandA, data_operandB;
  logic [W-1:0]     data_result, data_remainder;
  logic             data_exception, data_resultRDY, busy;
  div_state_e       dbg_state;

  int checks = 0;
  int failures = 0;
  logic [2*W:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  div_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- reference model ----------------
  // Returns {exception, remainder, quotient} from plain signed arithmetic.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    logic [W-1:0] q, r;
    if (b == '0) return {1'b1, a, {W{1'b0}}};
    if (a == MIN_INT && b == '1) return {1'b1, {W{1'b0}}, MIN_INT};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r, q};
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    bit special;
    special = (b == '0) || (a == MIN_INT && b == '1);
    return (special && EARLY) ? 1 : LAT;
  endfunction

  // ---------------- drivers ----------------
  // Returns at the start edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
  endtask

  // Counts edges after the start edge until RDY; operands are scrambled meanwhile.
  task automatic wait_done(output int edges, output int busy_cyc, output logic [2*W:0] got, output bit done);
    edges = 0;
    busy_cyc = 0;
    done = 1'b0;
    got = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      if (busy) busy_cyc++;
      if (data_resultRDY) begin
        done = 1'b1;
        got = {data_exception, data_remainder, data_result};
        break;
      end
      @(posedge clock);
      edges++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output int busy_cyc, output logic [2*W:0] got, output bit done);
    start_op(a, b);
    wait_done(edges, busy_cyc, got, done);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h exc=%b rdy=%b busy=%b want all zero",
               data_result, data_remainder, data_exception, data_resultRDY, busy);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int e, bc;
    logic [2*W:0] got, exp;
    bit done;
    exp = {1'b0, 32'd2, 32'd14};
    run_op(32'd100, 32'd7, e, bc, got, done);
    checks++;
    if (!done || got !== exp) begin
      failures++;
      $display("FAIL basic_100_7 got=%h want=%h done=%0d", got, exp, done);
    end
    checks++;
    if (e != LAT) begin
      failures++;
      $display("FAIL basic_latency got=%0d want=%0d", e, LAT);
    end
    checks++;
    if (bc != LAT) begin
      failures++;
      $display("FAIL basic_busy_cycles got=%0d want=%0d", bc, LAT);
    end
    @(negedge clock);
    checks++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0 || {data_exception, data_remainder, data_result} !== exp) begin
      failures++;
      $display("FAIL basic_hold rdy=%b busy=%b got=%h want=%h", data_resultRDY, busy,
               {data_exception, data_remainder, data_result}, exp);
    end
  endtask

  task automatic test_signs;
    logic [W-1:0] a_t[3] = '{-32'd100, 32'd100, -32'd100};
    logic [W-1:0] b_t[3] = '{32'd7, -32'd7, -32'd7};
    logic [2*W:0] e_t[3] = '{{1'b0, -32'd2, -32'd14}, {1'b0, 32'd2, -32'd14}, {1'b0, -32'd2, 32'd14}};
    int e, bc;
    logic [2*W:0] got;
    bit done;
    for (int i = 0; i < 3; i++) begin
      run_op(a_t[i], b_t[i], e, bc, got, done);
      checks++;
      if (!done || got !== e_t[i] || e != LAT) begin
        failures++;
        $display("FAIL signs_%0d got=%h want=%h lat=%0d want_lat=%0d", i, got, e_t[i], e, LAT);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] a_t[2] = '{32'd5, -32'd9};
    int e, bc;
    logic [2*W:0] got, exp;
    bit done;
    for (int i = 0; i < 2; i++) begin
      exp = {1'b1, a_t[i], 32'd0};
      run_op(a_t[i], 32'd0, e, bc, got, done);
      checks++;
      if (!done || got !== exp) begin
        failures++;
        $display("FAIL div_zero_%0d got=%h want=%h", i, got, exp);
      end
      checks++;
      if (e != (EARLY ? 1 : LAT) || bc != e) begin
        failures++;
        $display("FAIL div_zero_latency_%0d got=%0d busy=%0d want=%0d", i, e, bc, EARLY ? 1 : LAT);
      end
    end
  endtask

  task automatic test_overflow;
    int e, bc;
    logic [2*W:0] got, exp;
    bit done;
    exp = {1'b1, 32'd0, 32'h8000_0000};
    run_op(32'h8000_0000, 32'hFFFF_FFFF, e, bc, got, done);
    checks++;
    if (!done || got !== exp || e != (EARLY ? 1 : LAT)) begin
      failures++;
      $display("FAIL overflow_min_m1 got=%h want=%h lat=%0d", got, exp, e);
    end
    // exception from the previous op must drop as soon as a new op starts
    start_op(32'd8, 32'd2);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    checks++;
    if (data_exception !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL exc_clear_on_start exc=%b busy=%b want exc=0 busy=1", data_exception, busy);
    end
    @(posedge clock);
    wait_done(e, bc, got, done);
    exp = {1'b0, 32'd0, 32'h8000_0000};
    run_op(32'h8000_0000, 32'd1, e, bc, got, done);
    checks++;
    if (!done || got !== exp || e != LAT) begin
      failures++;
      $display("FAIL min_div_1 got=%h want=%h lat=%0d", got, exp, e);
    end
  endtask

  task automatic test_abort;
    int e, bc, early_rdy;
    logic [2*W:0] got, exp;
    bit done;
    exp = {1'b0, 32'd0, 32'd9};
    early_rdy = 0;
    start_op(32'd100, 32'd7);
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      if (data_resultRDY) early_rdy++;
      @(posedge clock);
    end
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd81;
    data_operandB = 32'd9;
    @(posedge clock);
    wait_done(e, bc, got, done);
    checks++;
    if (!done || got !== exp || e != LAT || early_rdy != 0) begin
      failures++;
      $display("FAIL abort_restart got=%h want=%h lat=%0d want_lat=%0d stray_rdy=%0d", got, exp, e, LAT, early_rdy);
    end
  endtask

  task automatic test_reset_mid;
    int e, bc, stray;
    logic [2*W:0] got, exp;
    bit done;
    stray = 0;
    start_op(32'd100, 32'd7);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({data_result, data_remainder, data_exception, data_resultRDY, busy} !== '0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h/%h exc=%b rdy=%b busy=%b state=%0d want zero/IDLE",
               data_result, data_remainder, data_exception, data_resultRDY, busy, dbg_state);
    end
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_mid_no_rdy got=%0d pulses want=0", stray);
    end
    exp = {1'b0, 32'd2, 32'd6};
    run_op(32'd20, 32'd3, e, bc, got, done);
    checks++;
    if (!done || got !== exp || e != LAT) begin
      failures++;
      $display("FAIL reset_mid_fresh got=%h want=%h lat=%0d", got, exp, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, b1, a2, b2;
    int e, bc, stray;
    logic [2*W:0] got, exp;
    bit done;
    a1 = $urandom;
    b1 = $urandom_range(1, 1000);
    a2 = $urandom;
    b2 = $urandom;
    exp_q.push_back(model(a1, b1));
    exp_q.push_back(model(a2, b2));
    stray = 0;
    start_op(a1, b1);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      if (data_resultRDY) stray++;
      @(posedge clock);
    end
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = a2;
    data_operandB = b2;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (data_resultRDY !== 1'b1 || busy !== 1'b1 || stray != 0 ||
        {data_exception, data_remainder, data_result} !== exp) begin
      failures++;
      $display("FAIL b2b_first rdy=%b busy=%b stray=%0d got=%h want=%h", data_resultRDY, busy, stray,
               {data_exception, data_remainder, data_result}, exp);
    end
    @(posedge clock);
    wait_done(e, bc, got, done);
    exp = exp_q.pop_front();
    checks++;
    if (!done || got !== exp || e + 1 != model_lat(a2, b2)) begin
      failures++;
      $display("FAIL b2b_second got=%h want=%h lat=%0d want_lat=%0d", got, exp, e + 1, model_lat(a2, b2));
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    int e, bc, kind;
    logic [2*W:0] got, exp;
    bit done;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      b = $urandom;
      kind = $urandom_range(0, 6);
      case (kind)
        0: b = '0;
        1: a = MIN_INT;
        2: b = '1;
        3: b = $urandom_range(1, 15);
        4: begin a = MIN_INT; b = '1; end
        default: ;
      endcase
      exp_q.push_back(model(a, b));
      run_op(a, b, e, bc, got, done);
      exp = exp_q.pop_front();
      checks++;
      if (!done || got !== exp || e != model_lat(a, b) || bc != e) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h got=%h want=%h lat=%0d busy=%0d want_lat=%0d",
                 n, a, b, got, exp, e, bc, model_lat(a, b));
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_overflow();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
